// File: rtl/atomrvcore_iccm_loader_if.sv
// Byte-stream and ICCM write-port bundle for the boot loader.
// The loader takes the slave side. The byte source and the ICCM side take the master side.
interface atomrvcore_iccm_loader_if #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 32
);
    logic                 start_i;
    logic [15:0]          len_words_i;
    logic                 byte_valid_i;
    logic [7:0]           byte_i;
    logic                 byte_ready_o;
    logic                 iccm_we_o;
    logic [ADDRWIDTH-1:0] iccm_addr_o;
    logic [DATAWIDTH-1:0] iccm_data_o;

    modport slave (
        input  start_i, len_words_i, byte_valid_i, byte_i,
        output byte_ready_o, iccm_we_o, iccm_addr_o, iccm_data_o
    );

    modport master (
        output start_i, len_words_i, byte_valid_i, byte_i,
        input  byte_ready_o, iccm_we_o, iccm_addr_o, iccm_data_o
    );
endinterface

// File: rtl/atomrvcore_iccm_loader.sv
// Boot-time ICCM loader. It holds the core in PC reset and packs a little-endian byte
// stream into 32-bit words. It writes each word through the ICCM write port, then
// releases the core after a short settle window. Every output is a register or a
// decode of the registered state, so no input reaches an output combinationally.
module atomrvcore_iccm_loader #(
    parameter int unsigned          DATAWIDTH      = 32,
    parameter int unsigned          ADDRWIDTH      = 32,
    parameter logic [ADDRWIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned          DEPTH_WORDS    = 1024,
    parameter int unsigned          TIMEOUT        = 1023,
    parameter int unsigned          RELEASE_CYCLES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    atomrvcore_iccm_loader_if.slave        bus,
    output logic                           core_rst_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_RELEASE,
        S_RUN,
        S_ERR
    } state_e;

    state_e               state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          idx_q, idx_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [23:0]          buf_q, buf_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [REL_W-1:0]     rel_q, rel_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic                 len_ok;

    // State and datapath registers, with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            buf_q   <= '0;
            tmo_q   <= '0;
            rel_q   <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            buf_q   <= buf_d;
            tmo_q   <= tmo_d;
            rel_q   <= rel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic. The ICCM address and data are loaded when byte 3 arrives,
    // so the WRITE cycle drives them straight from registers.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        buf_d   = buf_q;
        tmo_d   = tmo_q;
        rel_d   = rel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        len_ok  = (bus.len_words_i != '0) && (32'(bus.len_words_i) <= DEPTH_WORDS);

        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (bus.start_i) begin
                    if (len_ok) begin
                        state_d = S_COLLECT;
                        len_d   = bus.len_words_i;
                        idx_d   = '0;
                        bcnt_d  = '0;
                        tmo_d   = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_COLLECT: begin
                if (bus.byte_valid_i) begin
                    // A byte arriving on the timeout edge takes priority over the abort.
                    tmo_d  = '0;
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: buf_d[7:0]   = bus.byte_i;
                        2'd1: buf_d[15:8]  = bus.byte_i;
                        2'd2: buf_d[23:16] = bus.byte_i;
                        default: begin
                            data_d  = {bus.byte_i, buf_q};
                            addr_d  = BASE_ADDR + ADDRWIDTH'({idx_q, 2'b00});
                            state_d = S_WRITE;
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                idx_d  = idx_q + 16'd1;
                bcnt_d = '0;
                tmo_d  = '0;
                rel_d  = '0;
                if (idx_q + 16'd1 == len_q) begin
                    state_d = (RELEASE_CYCLES == 0) ? S_RUN : S_RELEASE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_RELEASE: begin
                if (rel_q == REL_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        bus.byte_ready_o = (state_q == S_COLLECT);
        bus.iccm_we_o    = (state_q == S_WRITE);
        bus.iccm_addr_o  = addr_q;
        bus.iccm_data_o  = data_q;
        core_rst_o       = (state_q != S_RUN);
        busy_o           = (state_q == S_COLLECT) || (state_q == S_WRITE) ||
                           (state_q == S_RELEASE);
        done_o           = (state_q == S_RUN);
        err_o            = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_atomrvcore_iccm_loader.sv
// Directed bench for atomrvcore_iccm_loader. Two instances share the same stimulus:
// dut0 uses BASE_ADDR 0 and dut1 uses BASE_ADDR 0x100. Each instance has a write
// monitor that records every ICCM write, and the recorded writes are compared
// against hand-computed words.
module tb_atomrvcore_iccm_loader;

    localparam int unsigned TIMEOUT = 1023;
    localparam logic [31:0] BASE1   = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic        valid;
    logic [7:0]  bt;

    logic core_rst0, busy0, done0, err0;
    logic core_rst1, busy1, done1, err1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned rdy_in_we = 0;
    logic [63:0] wq0[$];
    logic [63:0] wq1[$];

    atomrvcore_iccm_loader_if if0 ();
    atomrvcore_iccm_loader_if if1 ();

    assign if0.start_i      = start;
    assign if0.len_words_i  = len;
    assign if0.byte_valid_i = valid;
    assign if0.byte_i       = bt;
    assign if1.start_i      = start;
    assign if1.len_words_i  = len;
    assign if1.byte_valid_i = valid;
    assign if1.byte_i       = bt;

    atomrvcore_iccm_loader dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if0.slave),
        .core_rst_o(core_rst0), .busy_o(busy0), .done_o(done0), .err_o(err0)
    );

    atomrvcore_iccm_loader #(.BASE_ADDR(BASE1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1.slave),
        .core_rst_o(core_rst1), .busy_o(busy1), .done_o(done1), .err_o(err1)
    );

    always #5 clk = ~clk;

    // Record every write, and count cycles where ready was seen during a write
    always @(negedge clk) begin
        if (if0.iccm_we_o) begin
            wq0.push_back({if0.iccm_addr_o, if0.iccm_data_o});
            if (if0.byte_ready_o) rdy_in_we++;
        end
        if (if1.iccm_we_o) wq1.push_back({if1.iccm_addr_o, if1.iccm_data_o});
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        valid = 1'b0;
        repeat (gap) step();
        valid = 1'b1;
        bt    = b;
        for (int i = 0; i < 20 && !if0.byte_ready_o; i++) step();
        if (!if0.byte_ready_o) check_eq("ready_wait", 64'(if0.byte_ready_o), 64'd1);
        step();
        valid = 1'b0;
    endtask

    task automatic wait_done(input int unsigned max_cycles);
        for (int i = 0; i < int'(max_cycles) && !done0; i++) step();
        check_eq("done_reached", 64'(done0), 64'd1);
    endtask

    task automatic check_reset(input string p);
        check_eq({p, "_core_rst"}, 64'(core_rst0), 64'd1);
        check_eq({p, "_ready"},    64'(if0.byte_ready_o), 64'd0);
        check_eq({p, "_we"},       64'(if0.iccm_we_o), 64'd0);
        check_eq({p, "_addr0"},    64'(if0.iccm_addr_o), 64'd0);
        check_eq({p, "_addr1"},    64'(if1.iccm_addr_o), 64'(BASE1));
        check_eq({p, "_data"},     64'(if0.iccm_data_o), 64'd0);
        check_eq({p, "_busy"},     64'(busy0), 64'd0);
        check_eq({p, "_done"},     64'(done0), 64'd0);
        check_eq({p, "_err"},      64'(err0), 64'd0);
    endtask

    localparam logic [7:0]  T2_B [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'ha0, 8'hb1,
                                          8'hc2, 8'hd3, 8'hde, 8'had, 8'hbe, 8'hef};
    localparam int unsigned T2_G [12] = '{0, 3, 1, 0, 7, 2, 0, 0, 5, 1, 0, 4};
    localparam logic [31:0] T2_W [3]  = '{32'h44332211, 32'hd3c2b1a0, 32'hefbeadde};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b0, b1, r0;
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        valid = 1'b0;
        bt    = '0;
        step();
        step();
        check_reset("rst");
        rst_n = 1'b1;
        step();
        check_eq("idle_busy", 64'(busy0), 64'd0);
        check_eq("idle_core_rst", 64'(core_rst0), 64'd1);

        // 1: one-word load
        do_start(16'd1);
        check_eq("t1_busy", 64'(busy0), 64'd1);
        check_eq("t1_ready", 64'(if0.byte_ready_o), 64'd1);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        check_eq("t1_we", 64'(if0.iccm_we_o), 64'd1);
        check_eq("t1_ready_in_we", 64'(if0.byte_ready_o), 64'd0);
        check_eq("t1_wr0", {if0.iccm_addr_o, if0.iccm_data_o}, {32'h0, 32'h12345678});
        check_eq("t1_wr1", {if1.iccm_addr_o, if1.iccm_data_o}, {BASE1, 32'h12345678});
        repeat (4) step();
        check_eq("t1_rst_held", 64'(core_rst0), 64'd1);
        check_eq("t1_not_done", 64'(done0), 64'd0);
        step();
        check_eq("t1_rst_fall", 64'(core_rst0), 64'd0);
        check_eq("t1_done", 64'(done0), 64'd1);
        check_eq("t1_nwr", 64'(wq0.size()), 64'd1);

        // 2: three words with stalls, started from RUN
        b0 = wq0.size();
        b1 = wq1.size();
        r0 = rdy_in_we;
        do_start(16'd3);
        check_eq("t2_core_rst_reassert", 64'(core_rst0), 64'd1);
        check_eq("t2_done_clr", 64'(done0), 64'd0);
        for (int i = 0; i < 12; i++) send_byte(T2_B[i], T2_G[i]);
        wait_done(40);
        check_eq("t2_nwr0", 64'(wq0.size() - b0), 64'd3);
        check_eq("t2_nwr1", 64'(wq1.size() - b1), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (wq0.size() >= b0 + 3 && wq1.size() >= b1 + 3) begin
                check_eq($sformatf("t2_wr0_%0d", i), wq0[b0 + i], {32'(4 * i), T2_W[i]});
                check_eq($sformatf("t2_wr1_%0d", i), wq1[b1 + i], {BASE1 + 32'(4 * i), T2_W[i]});
            end
        end
        check_eq("t2_ready_in_we", 64'(rdy_in_we - r0), 64'd0);

        // 3: illegal lengths, then recovery
        b0 = wq0.size();
        do_start(16'd0);
        check_eq("t3_err_len0", 64'(err0), 64'd1);
        check_eq("t3_core_rst", 64'(core_rst0), 64'd1);
        check_eq("t3_busy", 64'(busy0), 64'd0);
        repeat (3) step();
        do_start(16'd1025);
        check_eq("t3_err_len1025", 64'(err0), 64'd1);
        repeat (2) step();
        check_eq("t3_nwr", 64'(wq0.size() - b0), 64'd0);
        do_start(16'd1);
        check_eq("t3_recover_err", 64'(err0), 64'd0);
        check_eq("t3_recover_busy", 64'(busy0), 64'd1);
        send_byte(8'hef, 0);
        send_byte(8'hbe, 0);
        send_byte(8'had, 0);
        send_byte(8'hde, 0);
        wait_done(20);
        if (wq0.size() > b0) check_eq("t3_wr", wq0[b0], {32'h0, 32'hdeadbeef});
        check_eq("t3_nwr2", 64'(wq0.size() - b0), 64'd1);

        // 4: timeout after two bytes, then a byte exactly on the timeout edge
        b0 = wq0.size();
        do_start(16'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        repeat (TIMEOUT - 1) step();
        check_eq("t4_no_err_early", 64'(err0), 64'd0);
        check_eq("t4_busy_early", 64'(busy0), 64'd1);
        step();
        check_eq("t4_err", 64'(err0), 64'd1);
        check_eq("t4_busy_clr", 64'(busy0), 64'd0);
        check_eq("t4_nwr", 64'(wq0.size() - b0), 64'd0);
        b0 = wq0.size();
        b1 = wq1.size();
        do_start(16'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, TIMEOUT - 1);
        check_eq("t4_edge_no_err", 64'(err0), 64'd0);
        check_eq("t4_edge_busy", 64'(busy0), 64'd1);
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        wait_done(20);
        check_eq("t4_nwr2", 64'(wq0.size() - b0), 64'd2);
        if (wq0.size() >= b0 + 2 && wq1.size() >= b1 + 2) begin
            check_eq("t4_wr0_0", wq0[b0],     {32'h0, 32'h04030201});
            check_eq("t4_wr0_1", wq0[b0 + 1], {32'h4, 32'h44332211});
            check_eq("t4_wr1_1", wq1[b1 + 1], {32'h104, 32'h44332211});
        end

        // 5: reset in the middle of a word
        check_eq("t5_run_core_rst", 64'(core_rst0), 64'd0);
        b0 = wq0.size();
        do_start(16'd2);
        check_eq("t5_core_rst_next", 64'(core_rst0), 64'd1);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset("t5");
        repeat (3) step();
        check_eq("t5_nwr", 64'(wq0.size() - b0), 64'd0);

        // 6: full-depth load from IDLE
        b0 = wq0.size();
        b1 = wq1.size();
        do_start(16'd1024);
        check_eq("t6_busy", 64'(busy0), 64'd1);
        for (int j = 0; j < 4096; j++) send_byte(8'(j), 0);
        wait_done(20);
        check_eq("t6_nwr", 64'(wq0.size() - b0), 64'd1024);
        if (wq0.size() >= b0 + 1024 && wq1.size() >= b1 + 1024) begin
            check_eq("t6_first", wq0[b0], {32'h0, 32'h03020100});
            check_eq("t6_last0", wq0[b0 + 1023], {32'hffc, 32'hfffefdfc});
            check_eq("t6_last1", wq1[b1 + 1023], {32'h10fc, 32'hfffefdfc});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atomrvcore_iccm_loader.md
# atomrvcore_iccm_loader

Boot-time program loader that sequences the instruction memory and the fetch unit's PC reset. It holds the core in reset and accepts a little-endian byte stream over a valid/ready handshake. It packs the bytes into 32-bit words, writes each word into the ICCM through its write port, then releases the core. It sits beside the ICCM, ahead of the fetch unit, and drives the ICCM write-enable, address and data path plus the PC reset.

## Interface

**Parameters**
- `DATAWIDTH`, 32: ICCM word width. Fixed at 32, i.e. 4 bytes per word.
- `ADDRWIDTH`, 32: ICCM byte-address width.
- `BASE_ADDR`, 0: byte address of the first loaded word.
- `DEPTH_WORDS`, 1024: ICCM capacity in words.
- `TIMEOUT`, 1023: maximum idle cycles allowed between bytes while collecting.
- `RELEASE_CYCLES`, 4: extra cycles PC reset is held after the last write.

**Ports**
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Synchronous, active-low.
- `start_i`, in, 1: begin a load. Sampled only in IDLE, RUN or ERR.
- `len_words_i`, in, 16: number of words to load. Sampled on an accepted start.
- `byte_valid_i`, in, 1: the byte on `byte_i` is valid.
- `byte_i`, in, 8: stream byte.
- `byte_ready_o`, out, 1: loader accepts a byte this cycle.
- `iccm_we_o`, out, 1: ICCM write enable (IWR_EN).
- `iccm_addr_o`, out, ADDRWIDTH: ICCM byte address.
- `iccm_data_o`, out, DATAWIDTH: ICCM write data.
- `core_rst_o`, out, 1: PC reset to the fetch unit. Active-high.
- `busy_o`, out, 1: a load is in progress (COLLECT, WRITE or RELEASE).
- `done_o`, out, 1: load completed and the core is running (RUN).
- `err_o`, out, 1: load aborted (ERR).

## Operation

**States:** IDLE, COLLECT, WRITE, RELEASE, RUN, ERR.

**IDLE**
- `core_rst_o`=1.
- `start_i`=1 with `len_words_i` in 1..`DEPTH_WORDS`: latch len, clear word index and byte count, go to COLLECT.
- `start_i`=1 with len=0 or len>`DEPTH_WORDS`: go to ERR. No write occurs.

**COLLECT**
- `byte_ready_o`=1.
- On each `byte_valid_i` & `byte_ready_o`:
  - byte k (0..3) goes into bits [8k+7:8k] of the word buffer;
  - byte count increments;
  - the timeout counter clears.
- On acceptance of byte 3: go to WRITE.
- Each cycle without a handshake increments the timeout counter. Counter width is clog2(`TIMEOUT`+1).
- When the counter reaches `TIMEOUT`: go to ERR. The partial word is discarded.

**WRITE** (exactly one cycle)
- `iccm_we_o`=1.
- `iccm_addr_o` = `BASE_ADDR` + 4·index, computed modulo 2^ADDRWIDTH.
- `iccm_data_o` = buffer.
- `byte_ready_o`=0.
- Index increments. If index+1 == len, go to RELEASE; otherwise go to COLLECT with byte count 0.

**RELEASE**
- `core_rst_o`=1 for `RELEASE_CYCLES` cycles, counted from 0.
- Then go to RUN.

**RUN**
- `core_rst_o`=0, `done_o`=1.
- `start_i`=1 reasserts `core_rst_o` in the following cycle and starts a new load, with the same len checks as IDLE.

**ERR**
- `core_rst_o`=1, `err_o`=1.
- `start_i` handling is identical to IDLE.

**Other rules**
- `start_i` is ignored in COLLECT, WRITE and RELEASE.
- Outside WRITE: `iccm_we_o`=0, and `iccm_addr_o` and `iccm_data_o` hold their last values.

## Timing

- **Reset values** (`rst_ni`=0 at a clock edge): state IDLE, `core_rst_o`=1, `byte_ready_o`=0, `iccm_we_o`=0, `iccm_addr_o`=`BASE_ADDR`, `iccm_data_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, all counters 0.
- **Reset mid-load:** same values. Any partial word is dropped and no write is issued.
- **Outputs:** all are registered, or decoded directly from registered state. No input-to-output combinational path exists, including `byte_ready_o`.
- **Start:** an accepted start at edge N gives `busy_o`=1 and `byte_ready_o`=1 from cycle N+1.
- **Write timing:** if byte 3 is accepted at edge N, `iccm_we_o`=1 in cycle N+1 only, and `byte_ready_o` returns to 1 in cycle N+2.
- **Throughput:** at most 1 word per 5 cycles.
- **Release timing:** if the last WRITE is cycle W, `core_rst_o` falls and `done_o` rises in cycle W+1+`RELEASE_CYCLES`.
- **Timeout:** if the last handshake is at edge N, ERR is entered at edge N+`TIMEOUT`. A handshake on that same edge wins: the byte is accepted and the counter clears.
- **Boundaries:**
  - len=`DEPTH_WORDS` is legal; the final address is `BASE_ADDR`+4·(`DEPTH_WORDS`−1).
  - `byte_valid_i` is don't-care whenever `byte_ready_o`=0, and no byte is consumed then.

## Test plan

1. **Reset, then one-word load.** Start with len=1 and bytes 0x78, 0x56, 0x34, 0x12 back-to-back. Required: one `iccm_we_o` pulse with addr=0x0 and data=0x12345678. `core_rst_o` falls 5 cycles after the write cycle, and `done_o`=1.
2. **Multi-word load with stalls.** Len=3, `BASE_ADDR`=0x100, 12 bytes with random `byte_valid_i` gaps shorter than `TIMEOUT`. Required: writes to 0x100, 0x104, 0x108 with the correctly packed data, exactly 3 `we` pulses, and `byte_ready_o`=0 during each WRITE cycle.
3. **Illegal length.** Start with len=0, then separately with len=`DEPTH_WORDS`+1. Required: ERR the next cycle, `err_o`=1, no `we` pulse, `core_rst_o`=1. A subsequent start with len=1 recovers and completes.
4. **Timeout.** Len=2, then send 2 bytes and stop. Required: ERR exactly `TIMEOUT` cycles after the second byte, and no write issued. Repeat with a byte arriving on the timeout edge: the byte is accepted and there is no error.
5. **Reset and reload.** During COLLECT, pull `rst_ni` low for one edge. Required: all outputs at reset values and no write. Separately, assert `start_i` in RUN. Required: `core_rst_o`=1 next cycle and a fresh load from index 0.
